hazard_unit: RTL

Pipeline interlock stage that sits between the ID stage and the IDEX register and in front of the instruction memory address port. It tracks in-flight register writes in a 3-entry scoreboard (EX/MEM/WB). It freezes PC and IF/ID and injects bubbles into IDEX whenever an ID-stage instruction reads a register still being produced. The register file has no write-through bypass and the datapath has no forwarding, so a RAW hazard lasts until the producer has left WB.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_if.sv | 38 +++
 rtl/hz_scoreboard.sv | 43 ++++
 rtl/hazard_unit.sv | 54 +++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the RAW interlock: scoreboard slot layout and
// the per-slot match helper used by the scoreboard.
package hazard_pkg;

   localparam int PC_W      = 8;
   localparam int RA_W      = 3;
   localparam int CNT_W     = 16;
   localparam int NUM_SLOTS = 3;

   typedef struct packed {
      logic            valid;
      logic [RA_W-1:0] rd;
   } sb_slot_t;

   function automatic logic raw_match(input sb_slot_t        slot,
                                      input logic [RA_W-1:0] rs,
                                      input logic            use_rs);
      return use_rs & slot.valid & (slot.rd == rs);
   endfunction

endpackage

// File: rtl/hazard_if.sv
// ID-stage / fetch-side bundle between the datapath (master) and the hazard unit (slave).
// Outputs are combinational functions of the inputs plus scoreboard state.
interface hazard_if;
   import hazard_pkg::*;

   logic [PC_W-1:0]  pc_next_i;
   logic [PC_W-1:0]  pc_current_i;
   logic             redirect_i;
   logic [RA_W-1:0]  id_rs1_i;
   logic [RA_W-1:0]  id_rs2_i;
   logic             id_use_rs1_i;
   logic             id_use_rs2_i;
   logic [RA_W-1:0]  id_rd_i;
   logic             id_reg_write_i;
   logic             id_mem_write_i;

   logic [PC_W-1:0]  hz_pc_o;
   logic             pc_en_o;
   logic             stall_o;
   logic             hz_reg_write_o;
   logic             hz_mem_write_o;
   logic [CNT_W-1:0] stall_cnt_o;

   modport master (
      output pc_next_i, pc_current_i, redirect_i,
      output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
      output id_rd_i, id_reg_write_i, id_mem_write_i,
      input  hz_pc_o, pc_en_o, stall_o, hz_reg_write_o, hz_mem_write_o, stall_cnt_o
   );

   modport slave (
      input  pc_next_i, pc_current_i, redirect_i,
      input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
      input  id_rd_i, id_reg_write_i, id_mem_write_i,
      output hz_pc_o, pc_en_o, stall_o, hz_reg_write_o, hz_mem_write_o, stall_cnt_o
   );

endinterface

// File: rtl/hz_scoreboard.sv
// Three-slot EX/MEM/WB shift register of pending writes; hit is combinational
// against the current ID sources, slots advance on every rising edge.
module hz_scoreboard
   import hazard_pkg::*;
#(
   parameter bit X0_HARDWIRED = 1'b1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [RA_W-1:0] rs1,
   input  logic [RA_W-1:0] rs2,
   input  logic            use_rs1,
   input  logic            use_rs2,
   input  logic            push_vld,
   input  logic [RA_W-1:0] push_rd,
   output logic            hit
);

   // index 0 = EX, 1 = MEM, 2 = WB
   sb_slot_t [NUM_SLOTS-1:0] slot_q;
   sb_slot_t                 ex_in;

   always_comb begin
      ex_in.valid = push_vld & ~(X0_HARDWIRED && (push_rd == '0));
      ex_in.rd    = push_rd;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_q <= '0;
      end else begin
         slot_q <= {slot_q[1], slot_q[0], ex_in};
      end
   end

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         hit = hit | raw_match(slot_q[i], rs1, use_rs1) | raw_match(slot_q[i], rs2, use_rs2);
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// RAW interlock between ID and IDEX: freezes PC/IF-ID and bubbles IDEX while a source is in flight.
// Zero-cycle combinational stall decision; the stall releases by itself once the producer leaves WB.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter bit X0_HARDWIRED = 1'b1
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   hazard_if.slave  ifc
);

   logic             hit;
   logic             push_vld;
   logic [CNT_W-1:0] stall_cnt_q;
   logic             unused_redirect;

   // A stalled instruction must not enter EX, otherwise it would be recorded twice.
   assign push_vld = ifc.id_reg_write_i & ~hit;

   hz_scoreboard #(
      .X0_HARDWIRED (X0_HARDWIRED)
   ) u_scoreboard (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .rs1      (ifc.id_rs1_i),
      .rs2      (ifc.id_rs2_i),
      .use_rs1  (ifc.id_use_rs1_i),
      .use_rs2  (ifc.id_use_rs2_i),
      .push_vld (push_vld),
      .push_rd  (ifc.id_rd_i),
      .hit      (hit)
   );

   // The datapath already folds a taken branch into pc_next_i; during a stall the
   // re-fetch of pc_current_i drops it because branch operands are not yet valid.
   assign unused_redirect = ifc.redirect_i;

   assign ifc.stall_o        = hit;
   assign ifc.pc_en_o        = ~hit;
   assign ifc.hz_pc_o        = hit ? ifc.pc_current_i : ifc.pc_next_i;
   assign ifc.hz_reg_write_o = ifc.id_reg_write_i & ~hit;
   assign ifc.hz_mem_write_o = ifc.id_mem_write_i & ~hit;
   assign ifc.stall_cnt_o    = stall_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_q <= '0;
      end else if (hit && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

endmodule
